// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU microcode sequencer: control-bit indices,
// microcode entry field layout helpers and the sequencer state encoding.
package cpu_pkg;

   // Control-word bit positions (PCO..CO) used by the CPU datapath.
   localparam int CO_BIT  = 0;
   localparam int J_BIT   = 1;
   localparam int CE_BIT  = 2;
   localparam int MI_BIT  = 3;
   localparam int RO_BIT  = 4;
   localparam int II_BIT  = 5;
   localparam int IO_BIT  = 6;
   localparam int AI_BIT  = 7;
   localparam int AO_BIT  = 8;
   localparam int EO_BIT  = 9;
   localparam int SU_BIT  = 10;
   localparam int BI_BIT  = 11;
   localparam int OI_BIT  = 12;
   localparam int RI_BIT  = 13;
   localparam int FI_BIT  = 14;
   localparam int PCO_BIT = 15;

   // Entry layout, LSB first: Cw, CondIdx, CondEn, Halt, End.
   function automatic int ci_width(input int flag_width);
      return (flag_width > 1) ? $clog2(flag_width) : 1;
   endfunction

   function automatic int cond_en_pos(input int cw_width, input int ci_w);
      return cw_width + ci_w;
   endfunction

   function automatic int halt_pos(input int cw_width, input int ci_w);
      return cw_width + ci_w + 1;
   endfunction

   function automatic int end_pos(input int cw_width, input int ci_w);
      return cw_width + ci_w + 2;
   endfunction

   function automatic int entry_width(input int cw_width, input int ci_w);
      return cw_width + ci_w + 3;
   endfunction

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/microcode_store.sv
// Writable microcode RAM: synchronous write, asynchronous read, no reset.
// A read of the address being written returns the old contents until the edge.
module microcode_store #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 24
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: step counter, RUN/HALT FSM and control-word gating.
// Optional macro MICRO_SEQUENCER_INSTR_COUNT_EN adds a 32-bit InstrCount output.
module micro_sequencer
   import cpu_pkg::*;
#(
   parameter int CW_WIDTH     = 20,
   parameter int OPCODE_WIDTH = 5,
   parameter int STEP_WIDTH   = 3,
   parameter int FLAG_WIDTH   = 2,
   parameter int FETCH_STEPS  = 2,
   parameter int J_BIT        = cpu_pkg::J_BIT,
   localparam int CI_W        = ci_width(FLAG_WIDTH),
   localparam int ENTRY_W     = entry_width(CW_WIDTH, CI_W),
   localparam int ADDR_W      = OPCODE_WIDTH + STEP_WIDTH
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic [OPCODE_WIDTH-1:0] OpCode,
   input  logic [FLAG_WIDTH-1:0]   Flags,
   input  logic                    Stall,
   input  logic                    UcWrEn,
   input  logic [ADDR_W-1:0]       UcWrAddr,
   input  logic [ENTRY_W-1:0]      UcWrData,
   output logic [CW_WIDTH-1:0]     ControlWord,
   output logic [STEP_WIDTH-1:0]   Step,
   output logic                    Halted,
   output logic                    InstrDone
`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
   ,output logic [31:0]            InstrCount
`endif
);

   logic [STEP_WIDTH-1:0]   step_q;
   seq_state_e              state_q;
   logic [OPCODE_WIDTH-1:0] rd_op;
   logic [ADDR_W-1:0]       rd_addr;
   logic [ENTRY_W-1:0]      entry;
   logic [CW_WIDTH-1:0]     e_cw;
   logic [CI_W-1:0]         e_idx;
   logic                    e_cond;
   logic                    e_halt;
   logic                    e_end;
   logic                    flag_sel;
   logic                    advance;
   logic                    last_step;
   logic [CW_WIDTH-1:0]     cw_gated;

   // Fetch steps are shared by every opcode and live under opcode 0.
   assign rd_op   = (int'(step_q) < FETCH_STEPS) ? '0 : OpCode;
   assign rd_addr = {rd_op, step_q};

   microcode_store #(
      .ADDR_W (ADDR_W),
      .DATA_W (ENTRY_W)
   ) u_store (
      .clk_i     (Clk),
      .wr_en_i   (UcWrEn),
      .wr_addr_i (UcWrAddr),
      .wr_data_i (UcWrData),
      .rd_addr_i (rd_addr),
      .rd_data_o (entry)
   );

   assign e_cw   = entry[CW_WIDTH-1:0];
   assign e_idx  = entry[CW_WIDTH +: CI_W];
   assign e_cond = entry[cond_en_pos(CW_WIDTH, CI_W)];
   assign e_halt = entry[halt_pos(CW_WIDTH, CI_W)];
   assign e_end  = entry[end_pos(CW_WIDTH, CI_W)];

   // Out-of-range condition indices fall back to flag 0.
   always_comb begin
      flag_sel = Flags[0];
      for (int i = 0; i < FLAG_WIDTH; i++) begin
         if (int'(e_idx) == i) flag_sel = Flags[i];
      end
   end

   always_comb begin
      cw_gated = e_cw;
      if (e_cond && !flag_sel) cw_gated[J_BIT] = 1'b0;
   end

   assign advance     = (state_q == ST_RUN) && !Stall && !Rst;
   assign last_step   = e_end || (step_q == '1);
   assign InstrDone   = advance && last_step;
   assign ControlWord = advance ? cw_gated : '0;
   assign Step        = step_q;
   assign Halted      = (state_q == ST_HALT);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         step_q  <= '0;
         state_q <= ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (!Stall) begin
                  step_q <= last_step ? '0 : step_q + 1'b1;
                  if (e_halt) state_q <= ST_HALT;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
   logic [31:0] instr_count_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         instr_count_q <= '0;
      end else if (InstrDone) begin
         instr_count_q <= instr_count_q + 32'd1;
      end
   end

   assign InstrCount = instr_count_q;
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with default parameters.
// Covers InstrCount only when MICRO_SEQUENCER_INSTR_COUNT_EN is defined.
module tb_micro_sequencer;

   logic        Clk;
   logic        Rst;
   logic [4:0]  OpCode;
   logic [1:0]  Flags;
   logic        Stall;
   logic        UcWrEn;
   logic [7:0]  UcWrAddr;
   logic [23:0] UcWrData;
   logic [19:0] ControlWord;
   logic [2:0]  Step;
   logic        Halted;
   logic        InstrDone;
`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
   logic [31:0] InstrCount;
`endif

   int checks = 0;
   int errors = 0;

   micro_sequencer dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .OpCode      (OpCode),
      .Flags       (Flags),
      .Stall       (Stall),
      .UcWrEn      (UcWrEn),
      .UcWrAddr    (UcWrAddr),
      .UcWrData    (UcWrData),
      .ControlWord (ControlWord),
      .Step        (Step),
      .Halted      (Halted),
      .InstrDone   (InstrDone)
`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
      ,.InstrCount (InstrCount)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic uc_write(input logic [4:0] op, input logic [2:0] st, input logic e_end,
                           input logic e_halt, input logic e_cond, input logic e_idx,
                           input logic [19:0] cw);
      UcWrEn   = 1'b1;
      UcWrAddr = {op, st};
      UcWrData = {e_end, e_halt, e_cond, e_idx, cw};
      tick();
      UcWrEn   = 1'b0;
   endtask

   task automatic test_reset();
      Rst = 1'b1; Stall = 1'b0; OpCode = 5'd0; Flags = 2'b00;
      UcWrEn = 1'b0; UcWrAddr = '0; UcWrData = '0;
      tick(); tick();
      uc_write(5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00009);
      uc_write(5'd0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 20'h01024);
      uc_write(5'd3, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 20'h000C0);
      uc_write(5'd5, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 20'h00002);
      for (int s = 2; s < 8; s++)
         uc_write(5'd6, 3'(s), 1'b0, 1'b0, 1'b0, 1'b0, 20'h00100 | 20'(s));
      uc_write(5'd7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 20'h000F0);
      uc_write(5'd7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 20'h00000);
      uc_write(5'd8, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 20'h00055);
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d want 0", Step); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", Halted); end
      checks++; if (InstrDone !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", InstrDone); end
      checks++; if (ControlWord !== 20'h0) begin errors++; $display("FAIL reset_cw got %h want 00000", ControlWord); end
      Rst = 1'b0; OpCode = 5'd3; #1;
      checks++; if (ControlWord !== 20'h00009) begin errors++; $display("FAIL reset_fetch_cw got %h want 00009", ControlWord); end
   endtask

   task automatic test_basic();
      logic [19:0] exp_cw [3];
      logic        exp_done [3];
      exp_cw   = '{20'h00009, 20'h01024, 20'h000C0};
      exp_done = '{1'b0, 1'b0, 1'b1};
      OpCode = 5'd3; #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (Step !== 3'(i)) begin errors++; $display("FAIL basic_step got %0d want %0d", Step, i); end
         checks++; if (ControlWord !== exp_cw[i]) begin errors++; $display("FAIL basic_cw step%0d got %h want %h", i, ControlWord, exp_cw[i]); end
         checks++; if (InstrDone !== exp_done[i]) begin errors++; $display("FAIL basic_done step%0d got %b want %b", i, InstrDone, exp_done[i]); end
         tick();
      end
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL basic_return got %0d want 0", Step); end
   endtask

   task automatic test_cond_jump();
      logic [1:0]  pat [3];
      logic [19:0] exp_cw [3];
      pat    = '{2'b10, 2'b00, 2'b01};
      exp_cw = '{20'h00002, 20'h00000, 20'h00000};
      for (int p = 0; p < 3; p++) begin
         OpCode = 5'd5; Flags = pat[p]; #1;
         tick(); tick();
         checks++; if (Step !== 3'd2) begin errors++; $display("FAIL cond_step got %0d want 2", Step); end
         checks++; if (ControlWord !== exp_cw[p]) begin errors++; $display("FAIL cond_cw flags=%b got %h want %h", pat[p], ControlWord, exp_cw[p]); end
         checks++; if (InstrDone !== 1'b1) begin errors++; $display("FAIL cond_done got %b want 1", InstrDone); end
         tick();
      end
      Flags = 2'b00;
   endtask

   task automatic test_wrap();
      logic [19:0] exp_cw;
      OpCode = 5'd6; #1;
      for (int i = 0; i < 8; i++) begin
         exp_cw = (i == 0) ? 20'h00009 : (i == 1) ? 20'h01024 : (20'h00100 | 20'(i));
         checks++; if (Step !== 3'(i)) begin errors++; $display("FAIL wrap_step got %0d want %0d", Step, i); end
         checks++; if (ControlWord !== exp_cw) begin errors++; $display("FAIL wrap_cw step%0d got %h want %h", i, ControlWord, exp_cw); end
         checks++; if (InstrDone !== (i == 7)) begin errors++; $display("FAIL wrap_done step%0d got %b want %b", i, InstrDone, (i == 7)); end
         tick();
      end
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL wrap_return got %0d want 0", Step); end
   endtask

   task automatic test_stall();
      OpCode = 5'd6; #1;
      tick(); tick();
      Stall = 1'b1; #1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (Step !== 3'd2) begin errors++; $display("FAIL stall_step cyc%0d got %0d want 2", i, Step); end
         checks++; if (ControlWord !== 20'h0) begin errors++; $display("FAIL stall_cw cyc%0d got %h want 00000", i, ControlWord); end
         checks++; if (InstrDone !== 1'b0) begin errors++; $display("FAIL stall_done cyc%0d got %b want 0", i, InstrDone); end
         tick();
      end
      Stall = 1'b0; #1;
      checks++; if (Step !== 3'd2) begin errors++; $display("FAIL stall_release_step got %0d want 2", Step); end
      checks++; if (ControlWord !== 20'h00102) begin errors++; $display("FAIL stall_release_cw got %h want 00102", ControlWord); end
      tick();
      checks++; if (Step !== 3'd3) begin errors++; $display("FAIL stall_next_step got %0d want 3", Step); end
      checks++; if (ControlWord !== 20'h00103) begin errors++; $display("FAIL stall_next_cw got %h want 00103", ControlWord); end
      repeat (5) tick();
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL stall_finish got %0d want 0", Step); end
   endtask

   task automatic test_halt();
      OpCode = 5'd7; #1;
      tick(); tick();
      checks++; if (ControlWord !== 20'h000F0) begin errors++; $display("FAIL halt_cw got %h want 000F0", ControlWord); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_early got %b want 0", Halted); end
      tick();
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", Halted); end
      checks++; if (ControlWord !== 20'h0) begin errors++; $display("FAIL halt_cw_zero got %h want 00000", ControlWord); end
      checks++; if (Step !== 3'd3) begin errors++; $display("FAIL halt_step got %0d want 3", Step); end
      checks++; if (InstrDone !== 1'b0) begin errors++; $display("FAIL halt_done got %b want 0", InstrDone); end
      Stall = 1'b1; tick(); Stall = 1'b0; tick();
      checks++; if (Step !== 3'd3) begin errors++; $display("FAIL halt_frozen got %0d want 3", Step); end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL halt_stays got %b want 1", Halted); end
      Rst = 1'b1; #1;
      checks++; if (ControlWord !== 20'h0) begin errors++; $display("FAIL halt_rst_cw got %h want 00000", ControlWord); end
      tick();
      Rst = 1'b0; #1;
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL halt_rst_step got %0d want 0", Step); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL halt_rst_flag got %b want 0", Halted); end
      checks++; if (ControlWord !== 20'h00009) begin errors++; $display("FAIL halt_rst_fetch got %h want 00009", ControlWord); end
   endtask

   task automatic test_end_halt();
      OpCode = 5'd8; #1;
      tick(); tick();
      checks++; if (ControlWord !== 20'h00055) begin errors++; $display("FAIL endhalt_cw got %h want 00055", ControlWord); end
      checks++; if (InstrDone !== 1'b1) begin errors++; $display("FAIL endhalt_done got %b want 1", InstrDone); end
      tick();
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL endhalt_step got %0d want 0", Step); end
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL endhalt_flag got %b want 1", Halted); end
      checks++; if (InstrDone !== 1'b0) begin errors++; $display("FAIL endhalt_done_after got %b want 0", InstrDone); end
      Rst = 1'b1; tick(); Rst = 1'b0; #1;
   endtask

   task automatic test_rst_mid();
      OpCode = 5'd3; #1;
      tick();
      Stall = 1'b1; Rst = 1'b1;
      tick();
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL rstmid_step got %0d want 0", Step); end
      Rst = 1'b0; Stall = 1'b0; #1;
      checks++; if (ControlWord !== 20'h00009) begin errors++; $display("FAIL rstmid_cw got %h want 00009", ControlWord); end
   endtask

   task automatic test_write_timing();
      OpCode   = 5'd3;
      UcWrEn   = 1'b1;
      UcWrAddr = {5'd0, 3'd0};
      UcWrData = {1'b0, 1'b0, 1'b0, 1'b0, 20'h00019};
      #1;
      checks++; if (ControlWord !== 20'h00009) begin errors++; $display("FAIL wr_old_cw got %h want 00009", ControlWord); end
      tick();
      UcWrEn = 1'b0; #1;
      checks++; if (ControlWord !== 20'h01024) begin errors++; $display("FAIL wr_step1_cw got %h want 01024", ControlWord); end
      tick(); tick();
      checks++; if (Step !== 3'd0) begin errors++; $display("FAIL wr_step got %0d want 0", Step); end
      checks++; if (ControlWord !== 20'h00019) begin errors++; $display("FAIL wr_new_cw got %h want 00019", ControlWord); end
   endtask

`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
   task automatic test_instr_count();
      Rst = 1'b1; tick(); Rst = 1'b0; OpCode = 5'd3; #1;
      checks++; if (InstrCount !== 32'd0) begin errors++; $display("FAIL count_start got %0d want 0", InstrCount); end
      repeat (12) tick();
      checks++; if (InstrCount !== 32'd4) begin errors++; $display("FAIL count_four got %0d want 4", InstrCount); end
      Rst = 1'b1; tick();
      checks++; if (InstrCount !== 32'd0) begin errors++; $display("FAIL count_reset got %0d want 0", InstrCount); end
      Rst = 1'b0; #1;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_cond_jump();
      test_wrap();
      test_stall();
      test_halt();
      test_end_halt();
      test_rst_mid();
      test_write_timing();
`ifdef MICRO_SEQUENCER_INSTR_COUNT_EN
      test_instr_count();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
